// File: rtl/ula_pkg.sv
// Shared types for the ULA result selector.
// Holds the FSM state enum and the opcode constants.
package ula_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_OR   = 2;
  localparam int OP_AND  = 3;
  localparam int OP_XOR  = 4;
  localparam int OP_MUL  = 5;
  localparam int OP_DIV  = 6;
  localparam int OP_NONE = 7;

endpackage

// File: rtl/ula_result_sel_if.sv
// Request/result bundle between operation units and the selector.
// master: drives start/op/in_data/in_valid/out_ready; slave: the selector.
interface ula_result_sel_if #(
  parameter int WIDTH   = 4,
  parameter int NUM_OPS = 8
);
  localparam int SEL_W =
    (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

  logic                     start;
  logic [SEL_W-1:0]         op;
  logic [NUM_OPS*WIDTH-1:0] in_data;
  logic [NUM_OPS-1:0]       in_valid;
  logic [WIDTH-1:0]         out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;
  logic                     zero;
  logic                     err;

  modport master (
    output start, op, in_data, in_valid,
    output out_ready,
    input  out_data, out_valid, busy,
    input  zero, err
  );

  modport slave (
    input  start, op, in_data, in_valid,
    input  out_ready,
    output out_data, out_valid, busy,
    output zero, err
  );
endinterface

// File: rtl/ula_onehot_dec.sv
// Binary opcode to one-hot unit select.
// Ports: i_sel (binary index), o_onehot (NUM_OPS one-hot).
module ula_onehot_dec #(
  parameter int NUM_OPS = 8,
  parameter int SEL_W   = 3
) (
  input  logic [SEL_W-1:0]   i_sel,
  output logic [NUM_OPS-1:0] o_onehot
);

  for (genvar k = 0; k < NUM_OPS; k++) begin : g_oh
    assign o_onehot[k] = (i_sel == SEL_W'(k));
  end

endmodule

// File: rtl/ula_result_sel.sv
// Selects one operation unit's result, waits for its valid with a
// timeout, and holds the registered result until the consumer takes it.
// Ports: clk, rst (async, active-high), bus (slave side of the bundle).
module ula_result_sel
  import ula_pkg::*;
#(
  parameter int                 WIDTH   = 4,
  parameter int                 NUM_OPS = 8,
  parameter logic [NUM_OPS-1:0] OP_EN   = NUM_OPS'(8'h7F),
  parameter int                 TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  ula_result_sel_if.slave  bus
);

  localparam int SEL_W =
    (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam int NSEL  = 1 << SEL_W;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t           r_state;
  logic [SEL_W-1:0] r_op_q;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_busy;
  logic             r_zero;
  logic             r_err;

  logic [NSEL-1:0]    w_mask;
  logic               w_op_en;
  logic [NUM_OPS-1:0] w_onehot;
  logic [WIDTH-1:0]   w_sel_data;
  logic               w_sel_valid;

  // Codes past NUM_OPS read as disabled.
  for (genvar k = 0; k < NSEL; k++) begin : g_mask
    if (k < NUM_OPS) begin : g_on
      assign w_mask[k] = OP_EN[k];
    end else begin : g_off
      assign w_mask[k] = 1'b0;
    end
  end

  assign w_op_en = w_mask[bus.op];

  ula_onehot_dec #(
    .NUM_OPS (NUM_OPS),
    .SEL_W   (SEL_W)
  ) u_dec (
    .i_sel    (r_op_q),
    .o_onehot (w_onehot)
  );

  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    for (int k = 0; k < NUM_OPS; k++) begin
      w_sel_data  |= {WIDTH{w_onehot[k]}}
                   & bus.in_data[k*WIDTH +: WIDTH];
      w_sel_valid |= w_onehot[k] & bus.in_valid[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_op_q  <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_zero  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_op_q <= bus.op;
            r_busy <= 1'b1;
            if (w_op_en) begin
              r_state <= WAIT;
              r_cnt   <= '0;
            end else begin
              r_state <= DONE;
              r_data  <= '0;
              r_err   <= 1'b1;
              r_zero  <= 1'b0;
              r_valid <= 1'b1;
            end
          end
        end
        WAIT: begin
          // Valid wins over a coincident timeout.
          if (w_sel_valid) begin
            r_state <= DONE;
            r_data  <= w_sel_data;
            r_err   <= 1'b0;
            r_zero  <= (w_sel_data == '0);
            r_valid <= 1'b1;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_state <= DONE;
            r_data  <= '0;
            r_err   <= 1'b1;
            r_zero  <= 1'b0;
            r_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_data  = r_data;
  assign bus.out_valid = r_valid;
  assign bus.busy      = r_busy;
  assign bus.zero      = r_zero;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_ula_result_sel.sv
// Randomized check of ula_result_sel against a transaction model.
// Covers default build and an 8-bit, 5-op build.
module tb_ula_result_sel;
  import ula_pkg::*;

  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ula_result_sel_if #(.WIDTH(4), .NUM_OPS(8)) bus_a ();
  ula_result_sel_if #(.WIDTH(8), .NUM_OPS(5)) bus_b ();

  ula_result_sel #(
    .WIDTH(4), .NUM_OPS(8),
    .OP_EN(8'h7F), .TIMEOUT(TMO)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bus_a)
  );

  ula_result_sel #(
    .WIDTH(8), .NUM_OPS(5),
    .OP_EN(5'h1F), .TIMEOUT(TMO)
  ) u_dut8 (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transaction-level expectation: when out_valid shows up
  // (cycles after the start edge) and what it carries.
  function automatic void model(
    input  int         op,
    input  int         nops,
    input  int         mask,
    input  int         d,
    input  logic [7:0] data,
    output int         cyc,
    output logic [7:0] x,
    output bit         e,
    output bit         z);
    bit en;
    en = (op < nops) && (((mask >> op) & 1) == 1);
    if (!en) begin
      cyc = 1; x = 0; e = 1; z = 0;
    end else if (d < TMO) begin
      cyc = d + 2; x = data; e = 0; z = (data == 0);
    end else begin
      cyc = TMO + 1; x = 0; e = 1; z = 0;
    end
  endfunction

  // d: WAIT cycles before the selected unit raises valid.
  task automatic run_a(input int op, input int d,
                       input logic [3:0] data,
                       input int hold);
    int          cyc, seen;
    logic [7:0]  x;
    bit          e, z;
    logic [31:0] dv;
    logic [7:0]  vv;
    model(op, 8, 8'h7F, d, {4'h0, data}, cyc, x, e, z);
    dv = $urandom;
    dv[op*4 +: 4] = data;
    vv = 8'($urandom);
    vv[op] = 1'b0;
    bus_a.start     = 1'b1;
    bus_a.op        = 3'(op);
    bus_a.in_data   = dv;
    bus_a.in_valid  = vv;
    bus_a.out_ready = 1'b0;
    @(posedge clk);
    seen = 0;
    for (int c = 1; c <= 40 && seen == 0; c++) begin
      @(negedge clk);
      if (bus_a.out_valid) begin
        seen = c;
      end else begin
        chk("busy_wait", bus_a.busy, 1);
        dv = $urandom;
        dv[op*4 +: 4] = data;
        vv = 8'($urandom);
        vv[op] = (c - 1 >= d);
        bus_a.start    = 1'($urandom);
        bus_a.op       = 3'($urandom);
        bus_a.in_data  = dv;
        bus_a.in_valid = vv;
      end
    end
    chk("latency", seen, cyc);
    chk("data", bus_a.out_data, x[3:0]);
    chk("err", bus_a.err, e);
    chk("zero", bus_a.zero, z);
    chk("busy_done", bus_a.busy, 1);
    for (int h = 0; h < hold; h++) begin
      bus_a.start = 1'($urandom);
      @(negedge clk);
      chk("hold_valid", bus_a.out_valid, 1);
      chk("hold_data", bus_a.out_data, x[3:0]);
      chk("hold_err", bus_a.err, e);
    end
    bus_a.start     = 1'b0;
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    chk("accept_valid", bus_a.out_valid, 0);
    chk("accept_busy", bus_a.busy, 0);
    bus_a.out_ready = 1'b0;
  endtask

  task automatic run_b(input int op, input logic [7:0] data);
    int          cyc, seen;
    logic [7:0]  x;
    bit          e, z;
    logic [39:0] dv;
    model(op, 5, 5'h1F, 0, data, cyc, x, e, z);
    dv = {8'($urandom), 32'($urandom)};
    if (op < 5) dv[op*8 +: 8] = data;
    bus_b.start     = 1'b1;
    bus_b.op        = 3'(op);
    bus_b.in_data   = dv;
    bus_b.in_valid  = 5'h1F;
    bus_b.out_ready = 1'b0;
    @(posedge clk);
    seen = 0;
    for (int c = 1; c <= 10 && seen == 0; c++) begin
      @(negedge clk);
      bus_b.start = 1'b0;
      if (bus_b.out_valid) seen = c;
    end
    chk("b_latency", seen, cyc);
    chk("b_data", bus_b.out_data, x);
    chk("b_err", bus_b.err, e);
    chk("b_zero", bus_b.zero, z);
    bus_b.out_ready = 1'b1;
    @(negedge clk);
    chk("b_accept", bus_b.out_valid, 0);
    bus_b.out_ready = 1'b0;
  endtask

  initial begin
    int cnt;
    bus_a.start = 0; bus_a.op = 0; bus_a.in_data = 0;
    bus_a.in_valid = 0; bus_a.out_ready = 0;
    bus_b.start = 0; bus_b.op = 0; bus_b.in_data = 0;
    bus_b.in_valid = 0; bus_b.out_ready = 0;

    repeat (2) @(negedge clk);
    chk("rst_valid", bus_a.out_valid, 0);
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_data", bus_a.out_data, 0);
    chk("rst_err", bus_a.err, 0);
    chk("rst_zero", bus_a.zero, 0);
    rst = 1'b0;

    // Directed cases first; the first start follows release.
    run_a(OP_ADD, 0, 4'h9, 0);
    run_a(OP_MUL, 4, 4'h0, 3);
    run_a(OP_NONE, 0, 4'h5, 2);
    run_a(OP_DIV, 99, 4'h3, 0);
    run_a(OP_DIV, TMO - 1, 4'h6, 1);
    run_a(OP_DIV, TMO, 4'h6, 0);

    repeat (40)
      run_a($urandom_range(0, 7), $urandom_range(0, 20),
            4'($urandom), $urandom_range(0, 3));

    // Reset mid-WAIT.
    bus_a.start = 1'b1; bus_a.op = 3'(OP_MUL);
    bus_a.in_valid = 8'h00;
    @(negedge clk);
    bus_a.start = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", bus_a.busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstw_busy", bus_a.busy, 0);
    chk("rstw_valid", bus_a.out_valid, 0);
    bus_a.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    bus_a.in_valid = 8'hFF;
    repeat (20) begin
      @(negedge clk);
      cnt += int'(bus_a.out_valid);
    end
    chk("rstw_no_pulse", cnt, 0);

    // Reset mid-DONE with err set.
    bus_a.start = 1'b1; bus_a.op = 3'(OP_NONE);
    @(negedge clk);
    bus_a.start = 1'b0;
    chk("pre_rstd_err", bus_a.err, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstd_err", bus_a.err, 0);
    chk("rstd_valid", bus_a.out_valid, 0);
    chk("rstd_busy", bus_a.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      cnt += int'(bus_a.out_valid);
    end
    chk("rstd_no_pulse", cnt, 0);

    // Back-to-back throughput: one result every 3 cycles.
    bus_a.op = 3'(OP_ADD);
    bus_a.in_valid = 8'hFF;
    bus_a.out_ready = 1'b1;
    bus_a.start = 1'b1;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      cnt += int'(bus_a.out_valid);
    end
    chk("throughput", cnt, 10);
    bus_a.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("drain_busy", bus_a.busy, 0);
    bus_a.out_ready = 1'b0;

    // Narrow/odd build.
    run_b(4, 8'hA5);
    run_b(6, 8'h11);
    run_b(0, 8'h00);
    repeat (12)
      run_b($urandom_range(0, 7), 8'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/ula_result_sel.md
ULA_RESULT_SEL -- requirements
Module: ula_result_sel

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the result bit width per operation unit.
REQ-002 Parameter NUM_OPS, default 8, SHALL set the number of selectable operation units; SEL_W = clog2(NUM_OPS) SHALL be derived, not overridable.
REQ-003 Parameter OP_EN, default 8'h7F, SHALL be a NUM_OPS-bit mask of implemented opcodes (bit 7, unused op, clear by default).
REQ-004 Parameter TIMEOUT, default 15, SHALL be the maximum cycles spent waiting for a unit's valid.
REQ-005 clk  input  1  single clock; all state rising-edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  request to select and capture a result for op.
REQ-008 op  input  SEL_W  opcode; 0 add, 1 sub, 2 or, 3 and, 4 xor, 5 mul, 6 div, 7 unused.
REQ-009 in_data  input  NUM_OPS*WIDTH  flattened unit results; slice k = bits [k*WIDTH +: WIDTH].
REQ-010 in_valid  input  NUM_OPS  per-unit result-valid; combinational units tie high.
REQ-011 out_data  output  WIDTH  captured result, registered.
REQ-012 out_valid  output  1  out_data/flags valid, held until accepted.
REQ-013 out_ready  input  1  consumer acceptance.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 zero  output  1  registered: captured result equals 0 and err low.
REQ-016 err  output  1  registered: disabled opcode or timeout.

Function
REQ-017 FSM SHALL have states IDLE, WAIT, DONE.
REQ-018 IDLE: on start=1, op SHALL be latched into op_q; if OP_EN[op]=1 next state WAIT with wait counter cleared, else next state DONE with out_data=0, err=1, zero=0.
REQ-019 start SHALL be ignored in WAIT and DONE; op changes after the start cycle SHALL have no effect.
REQ-020 WAIT: if in_valid[op_q]=1, slice op_q of in_data SHALL be captured into out_data, err=0, zero set per REQ-015, next state DONE.
REQ-021 WAIT: if in_valid[op_q]=0 and counter = TIMEOUT-1, next state DONE with out_data=0, err=1, zero=0; otherwise counter increments.
REQ-022 In-valid and timeout in the same cycle SHALL resolve as valid (capture, no error).
REQ-023 WAIT SHALL last at most TIMEOUT cycles; counter width clog2(TIMEOUT+1), no wrap.
REQ-024 DONE: out_valid=1; out_data, zero, err SHALL be stable until out_ready=1, then next state IDLE and out_valid=0 the following cycle.
REQ-025 Latency: start at cycle 0 with in_valid[op] high at cycle 1 SHALL give out_valid at cycle 2; back-to-back with out_ready tied high SHALL sustain one result per 3 cycles.
REQ-026 out_valid SHALL be low in IDLE and WAIT; in_valid of non-selected units SHALL be ignored.
REQ-027 op values >= NUM_OPS (non-power-of-two NUM_OPS) SHALL be treated as disabled.

Reset
REQ-028 rst=1 SHALL asynchronously force state IDLE, op_q=0, counter=0, out_data=0, out_valid=0, busy=0, zero=0, err=0.
REQ-029 Reset mid-WAIT or mid-DONE SHALL abandon the transaction with no output pulse after release.
REQ-030 First start SHALL be accepted on the first rising edge with rst low.

Structure
REQ-031 Shared package ula_pkg SHALL hold the state enum and opcode constants OP_ADD..OP_NONE.
REQ-032 One sub-module, ula_onehot_dec (op_q -> NUM_OPS one-hot), SHALL drive the AND-OR slice selection of in_data and in_valid.
REQ-033 No latches; all outputs driven from registers.

Verification
REQ-034 Defaults, start op=0, in_data slice0=4'h9, in_valid=8'hFF, out_ready=1 -> out_valid at cycle 2, out_data=9, zero=0, err=0.
REQ-035 start op=5, in_valid[5] raised 4 cycles later with slice5=4'h0 -> out_data=0, zero=1, err=0, out_valid held while out_ready=0 for 3 cycles.
REQ-036 start op=7 -> DONE next cycle, err=1, out_data=0, busy=1 until accepted.
REQ-037 start op=6, in_valid[6] never high -> exactly 15 WAIT cycles, then err=1, out_data=0; in_valid[6] and timeout coincident in a rerun -> capture, err=0.
REQ-038 rst asserted mid-WAIT (op=5) -> all outputs 0 immediately, no out_valid after release; start pulses during WAIT/DONE produce no extra results.
REQ-039 WIDTH=8, NUM_OPS=5, OP_EN=5'h1F: op=4 slice=8'hA5 -> out_data=8'hA5; op=6 -> err=1.
